// File: rtl/fp_norm_round.sv
// Post-adder normalize/round stage of the binary32 FPU: leading-zero normalization,
// round-to-nearest-even and packing, as a two-stage valid/ready pipeline.

module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);
    always_comb begin
        count = 5'd24;
        // Later (higher) set bits overwrite earlier ones, so the MSB wins.
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end
endmodule

module fp_norm_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+3:0]         in_man,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W-1:0]   out_result,
    output logic                     out_overflow,
    output logic                     out_underflow,
    output logic                     out_inexact
);
    localparam int FW = MAN_W + 3;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic             sign;
        logic [MAN_W-1:0] sig;
        logic             g;
        logic             r;
        logic             s;
        logic [XW-1:0]    exp;
        logic             zero;
        logic             ovf;
        logic             sub;
    } s1_t;

    logic s1_valid;
    logic s2_ready;
    s1_t  s1_next;
    s1_t  s1;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // ---------------- stage 1: normalize ----------------
    logic [XW-1:0] e_base;
    logic [XW-1:0] shift_limit;
    logic [4:0]    lz_hi;
    logic [4:0]    lz_lo;
    logic [5:0]    lz_sum;
    logic [4:0]    lz;
    logic [4:0]    sh;
    logic [FW-1:0] norm;

    assign e_base = (in_exp == '0) ? XW'(1) : XW'(in_exp);

    // The 27-bit field is split into the 24-bit significand and the 3 GRS bits.
    fp_lzc24 u_lzc_hi (.value(in_man[FW-1:3]),        .count(lz_hi));
    fp_lzc24 u_lzc_lo (.value({in_man[2:0], 21'b0}), .count(lz_lo));

    assign lz_sum      = (lz_hi == 5'd24) ? (6'd24 + {1'b0, lz_lo}) : {1'b0, lz_hi};
    assign lz          = (lz_sum > 6'd26) ? 5'd26 : lz_sum[4:0];
    assign shift_limit = e_base - XW'(1);
    assign sh          = (XW'(lz) > shift_limit) ? shift_limit[4:0] : lz;
    assign norm        = in_man[FW-1:0] << sh;

    always_comb begin
        // NOTE: every field gets a default first so no branch can infer a latch.
        s1_next      = '0;
        s1_next.sign = in_sign;
        s1_next.exp  = e_base;
        if (in_man == '0) begin
            s1_next.zero = 1'b1;
        end else if (in_man[FW]) begin
            s1_next.sig = in_man[FW:4];
            s1_next.g   = in_man[3];
            s1_next.r   = in_man[2];
            s1_next.s   = in_man[1] | in_man[0];
            s1_next.exp = e_base + XW'(1);
            s1_next.ovf = (e_base + XW'(1)) >= EXP_MAX;
        end else begin
            s1_next.sig = norm[FW-1:3];
            s1_next.g   = norm[2];
            s1_next.r   = norm[1];
            s1_next.s   = norm[0];
            s1_next.exp = e_base - XW'(sh);
            s1_next.sub = !norm[FW-1];
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic                   inexact;
    logic                   round_up;
    logic [MAN_W:0]         sum;
    logic [MAN_W-1:0]       r_sig;
    logic [XW-1:0]          r_exp;
    logic                   r_ovf;
    logic [EXP_W+MAN_W-1:0] res_result;
    logic                   res_ovf;
    logic                   res_unf;
    logic                   res_inx;

    assign inexact  = s1.g | s1.r | s1.s;
    assign round_up = s1.g & (s1.r | s1.s | s1.sig[0]);
    assign sum      = {1'b0, s1.sig} + (MAN_W + 1)'(round_up);

    always_comb begin
        r_sig = sum[MAN_W-1:0];
        r_exp = s1.exp;
        if (sum[MAN_W]) begin
            r_sig = {1'b1, {(MAN_W-1){1'b0}}};
            r_exp = s1.exp + XW'(1);
        end else if (s1.sub) begin
            // A subnormal that rounds into the hidden bit becomes the smallest normal.
            r_exp = XW'(r_sig[MAN_W-1]);
        end
        r_ovf = s1.ovf || (r_exp >= EXP_MAX);

        res_result = {s1.sign, r_exp[EXP_W-1:0], r_sig[MAN_W-2:0]};
        res_ovf    = 1'b0;
        res_unf    = inexact & s1.sub;
        res_inx    = inexact;
        if (s1.zero) begin
            res_result = {s1.sign, {(EXP_W+MAN_W-1){1'b0}}};
            res_unf    = 1'b0;
            res_inx    = 1'b0;
        end else if (r_ovf) begin
            res_result = {s1.sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            res_ovf    = 1'b1;
            res_unf    = 1'b0;
            res_inx    = 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    // NOTE: state uses non-blocking assignments so both stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the stage-1 payload is not reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1 <= s1_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= res_result;
                out_overflow  <= res_ovf;
                out_underflow <= res_unf;
                out_inexact   <= res_inx;
            end
        end
    end
endmodule
